// File: rtl/d_ff_pipe.sv
// ----------------------------------------------------------------------------
// d_ff_pipe
//   Parametrised register pipeline. A WIDTH-bit word and its valid bit are
//   delayed through DEPTH clock-enabled stages. A runtime tap selects which
//   stage drives q/q_valid. The last stage is always visible on q_last.
//   A running count of valid stages is kept in occupancy.
//
// Parameters
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of stages (>=1)
//   RESET_VAL  data value loaded into every stage on reset/clear
//   TW         tap select width, max(1, clog2(DEPTH))
//   CW         occupancy width, clog2(DEPTH+1)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   en          in   shift enable; the pipeline holds when low
//   clear       in   synchronous flush; same effect on contents as reset
//   d           in   input data, captured into stage 0 when en=1
//   d_valid     in   valid bit captured together with d
//   tap_sel     in   index of the stage routed to q/q_valid
//   q           out  data of stage tap_sel (RESET_VAL when out of range)
//   q_valid     out  valid bit of stage tap_sel (0 when out of range)
//   q_last      out  data of stage DEPTH-1
//   q_last_vld  out  valid bit of stage DEPTH-1
//   occupancy   out  number of stages whose valid bit is set
// ----------------------------------------------------------------------------
module d_ff_pipe #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned       CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_last,
    output logic             q_last_vld,
    output logic [CW-1:0]    occupancy
);

    localparam int unsigned TAPS = 1 << TW;

    // Stage 0 is the entry stage, stage DEPTH-1 the exit stage.
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            vld;

    logic [DEPTH-1:0][WIDTH-1:0] data_nx;
    logic [DEPTH-1:0]            vld_nx;

    // Shifted contents; a single stage simply reloads from the input.
    generate
        if (DEPTH == 1) begin : g_single
            assign data_nx = d;
            assign vld_nx  = d_valid;
        end else begin : g_multi
            assign data_nx = {data[DEPTH-2:0], d};
            assign vld_nx  = {vld[DEPTH-2:0], d_valid};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data      <= {DEPTH{RESET_VAL}};
            vld       <= '0;
            occupancy <= '0;
        end else if (en) begin
            data      <= data_nx;
            vld       <= vld_nx;
            // Entry and exit in the same cycle cancel; the count tracks popcount(vld).
            occupancy <= occupancy + CW'(d_valid) - CW'(vld[DEPTH-1]);
        end
    end

    // Tap table padded to the full tap_sel range so unused codes read as
    // RESET_VAL / invalid without any out-of-range array select.
    logic [TAPS-1:0][WIDTH-1:0] tap_data;
    logic [TAPS-1:0]            tap_vld;

    generate
        for (genvar g = 0; g < TAPS; g++) begin : g_tap
            if (g < DEPTH) begin : g_real
                assign tap_data[g] = data[g];
                assign tap_vld[g]  = vld[g];
            end else begin : g_pad
                assign tap_data[g] = RESET_VAL;
                assign tap_vld[g]  = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        q       = tap_data[tap_sel];
        q_valid = tap_vld[tap_sel];
    end

    assign q_last     = data[DEPTH-1];
    assign q_last_vld = vld[DEPTH-1];

endmodule

// File: tb/tb_d_ff_pipe.sv
module tb_d_ff_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, clear, d_valid;
    logic [7:0] d;
    logic [1:0] tap_sel, tap3;

    logic [7:0] q, q_last;
    logic       q_valid, q_last_vld;
    logic [2:0] occupancy;

    logic [7:0] q3, ql3;
    logic       qv3, qlv3;
    logic [1:0] occ3;

    d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel), .q(q), .q_valid(q_valid), .q_last(q_last),
        .q_last_vld(q_last_vld), .occupancy(occupancy)
    );

    // Three-stage build with a non-zero reset value, so an out-of-range tap
    // is distinguishable from real data.
    d_ff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5C)) dut3 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .d(d), .d_valid(d_valid),
        .tap_sel(tap3), .q(q3), .q_valid(qv3), .q_last(ql3),
        .q_last_vld(qlv3), .occupancy(occ3)
    );

    typedef struct {
        logic       en;
        logic       clear;
        logic       dv;
        logic [7:0] d;
        logic [1:0] tap;
        logic [7:0] eq;
        logic       eqv;
        logic [7:0] elast;
        logic       elv;
        logic [2:0] eocc;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       qv;
        logic [7:0] last;
        logic       lv;
        logic [2:0] occ;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];

    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One edge: the expected outputs are queued with the stimulus and popped
    // once the edge has been taken.
    task automatic step(input logic e, input logic c, input logic [7:0] dd,
                        input logic dv, input logic [1:0] t, input exp_t ex);
        exp_t got;
        en = e; clear = c; d = dd; d_valid = dv; tap_sel = t;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("q",          {24'd0, q},          {24'd0, got.q});
        check("q_valid",    {31'd0, q_valid},    {31'd0, got.qv});
        check("q_last",     {24'd0, q_last},     {24'd0, got.last});
        check("q_last_vld", {31'd0, q_last_vld}, {31'd0, got.lv});
        check("occupancy",  {29'd0, occupancy},  {29'd0, got.occ});
    endtask

    task automatic run_rows(input int lo, input int hi);
        exp_t ex;
        for (int i = lo; i <= hi; i++) begin
            ex = '{tbl[i].eq, tbl[i].eqv, tbl[i].elast, tbl[i].elv, tbl[i].eocc};
            step(tbl[i].en, tbl[i].clear, tbl[i].d, tbl[i].dv, tbl[i].tap, ex);
        end
    endtask

    logic [7:0] md[$];
    logic       mv[$];

    initial begin
        //               en    clr   dv    d      tap    q      qv    last   lv    occ
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 2'd0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 8'h11, 1'b1, 8'h00, 1'b0, 3'd2};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd2, 8'h11, 1'b1, 8'h00, 1'b0, 3'd3};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 8'h11, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 2'd1, 8'h33, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h5A, 2'd2, 8'h22, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 2'd3, 8'h11, 1'b1, 8'h11, 1'b1, 3'd4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h55, 2'd0, 8'h55, 1'b0, 8'h22, 1'b1, 3'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h66, 2'd1, 8'h55, 1'b0, 8'h33, 1'b1, 3'd3};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h77, 2'd3, 8'h44, 1'b1, 8'h44, 1'b1, 3'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h88, 2'd3, 8'h55, 1'b0, 8'h55, 1'b0, 3'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h99, 2'd2, 8'h77, 1'b0, 8'h66, 1'b1, 3'd2};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 8'hAA, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 8'hBB, 2'd0, 8'hBB, 1'b1, 8'h00, 1'b0, 3'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 8'hCC, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1};

        // Reset held two cycles while the inputs try to load a valid word.
        reset = 1'b1; en = 1'b1; clear = 1'b0; d = 8'hFF; d_valid = 1'b1;
        tap_sel = 2'd0; tap3 = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_q",          {24'd0, q},          32'h00);
            check("rst_q_valid",    {31'd0, q_valid},    32'h0);
            check("rst_q_last",     {24'd0, q_last},     32'h00);
            check("rst_q_last_vld", {31'd0, q_last_vld}, 32'h0);
            check("rst_occupancy",  {29'd0, occupancy},  32'h0);
        end
        check("rst3_q_last", {24'd0, ql3}, 32'h5C);
        check("rst3_q",      {24'd0, q3},  32'h5C);
        reset = 1'b0;

        // Fill with 11..44, then probe the three-stage build's taps.
        run_rows(0, 3);
        tap3 = 2'd2;
        #1;
        check("d3_tap2_q",     {24'd0, q3},   32'h22);
        check("d3_tap2_qv",    {31'd0, qv3},  32'h1);
        check("d3_occupancy",  {30'd0, occ3}, 32'h3);
        tap3 = 2'd3;
        #1;
        check("d3_oor_q",      {24'd0, q3},   32'h5C);
        check("d3_oor_qv",     {31'd0, qv3},  32'h0);
        tap3 = 2'd0;

        // Tap sweep during a stall, bubbles, flush priority.
        run_rows(4, 15);

        // Randomised run against a queue model; the first cycle flushes so
        // the model starts from a known state.
        md = '{8'h00, 8'h00, 8'h00, 8'h00};
        mv = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 1000; i++) begin
            logic       re, rc, rdv;
            logic [7:0] rd;
            logic [1:0] rt;
            exp_t       ex;
            int         pc;
            re  = ($urandom_range(0, 3) != 0);
            rc  = (i == 0) || ($urandom_range(0, 31) == 0);
            rd  = 8'($urandom);
            rdv = 1'($urandom_range(0, 1));
            rt  = 2'($urandom_range(0, 3));
            if (rc) begin
                for (int k = 0; k < 4; k++) begin
                    md[k] = 8'h00;
                    mv[k] = 1'b0;
                end
            end else if (re) begin
                md.push_front(rd);
                void'(md.pop_back());
                mv.push_front(rdv);
                void'(mv.pop_back());
            end
            pc = 0;
            for (int k = 0; k < 4; k++) pc += int'(mv[k]);
            ex = '{md[rt], mv[rt], md[3], mv[3], 3'(pc)};
            step(re, rc, rd, rdv, rt, ex);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
